// File: rtl/csr_file_pkg.sv
// Shared definitions for the machine-mode CSR file: CSR selector and
// operation encodings, writable-bit masks and fixed field values, plus the
// read-modify-write helper used by CSR instructions.
package csr_file_pkg;

  // Compact 4-bit CSR selector produced by decode. 4'b0101 is deliberately
  // left unmapped so decode can flag it as illegal.
  typedef enum logic [3:0] {
    CSR_MSTATUS   = 4'd0,
    CSR_MISA      = 4'd1,
    CSR_MIE       = 4'd2,
    CSR_MTVEC     = 4'd3,
    CSR_MSCRATCH  = 4'd4,
    CSR_UNMAPPED  = 4'd5,
    CSR_MEPC      = 4'd6,
    CSR_MCAUSE    = 4'd7,
    CSR_MTVAL     = 4'd8,
    CSR_MIP       = 4'd9,
    CSR_MCYCLE    = 4'd10,
    CSR_MINSTRET  = 4'd11,
    CSR_MVENDORID = 4'd12,
    CSR_MARCHID   = 4'd13,
    CSR_MIMPID    = 4'd14,
    CSR_MHARTID   = 4'd15
  } destinationCSR_;

  typedef enum logic [1:0] {
    CSR_NONE = 2'd0,
    CSR_RW   = 2'd1,
    CSR_RS   = 2'd2,
    CSR_RC   = 2'd3
  } CSROp_;

  localparam logic [31:0] MSTATUS_WMASK = 32'h0000_0088;
  localparam logic [31:0] MIE_WMASK     = 32'h0000_0888;
  localparam logic [1:0]  MSTATUS_MPP   = 2'b11;
  localparam logic [31:0] MISA_DEFAULT  = 32'h4000_0100;

  // Result of a CSR instruction given the current value and the operand.
  function automatic logic [31:0] csrOpResult(input CSROp_ op,
                                              input logic [31:0] current,
                                              input logic [31:0] operand);
    logic [31:0] result;
    case (op)
      CSR_RW:  result = operand;
      CSR_RS:  result = current | operand;
      CSR_RC:  result = current & ~operand;
      default: result = current;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/csr_file_counter.sv
// csr_counter: 32-bit wrapping counter with increment enable and a
// parallel load. LOAD_PRIORITY=1 lets a load win over an increment in the
// same cycle; LOAD_PRIORITY=0 lets the increment win instead.
// Ports: clock, reset (async, active high), incEnable, loadEnable,
//        loadValue[31:0], count[31:0].
module csr_counter #(
  parameter bit LOAD_PRIORITY = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        incEnable,
  input  logic        loadEnable,
  input  logic [31:0] loadValue,
  output logic [31:0] count
);

  // Counter register; wraps naturally from all-ones to zero.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (LOAD_PRIORITY) begin
      if (loadEnable)     count <= loadValue;
      else if (incEnable) count <= count + 32'd1;
    end else begin
      if (incEnable)       count <= count + 32'd1;
      else if (loadEnable) count <= loadValue;
    end
  end

endmodule

// File: rtl/csr_file.sv
// csr_file: machine-mode CSR register file for a small RV32I core.
// Reads are combinational from registered state only; CSR instruction
// writes, trap entry and MRET update state on the next clock edge.
// Ports:
//   clock, reset                       clock and async active-high reset
//   readCSR / readData / readIllegal   execute-stage read port
//   writeValid, writeCSR, writeOp,
//   writeIntent, writeOperand          writeback-stage CSR instruction
//   retire                             instruction retired (MINSTRET)
//   trapValid, trapPC, trapCause       trap entry
//   mretValid                          MRET commit
//   trapTarget, mretTarget,
//   interruptEnable                    MTVEC, MEPC, MSTATUS.MIE
module csr_file
  import csr_file_pkg::*;
#(
  parameter logic [31:0] HART_ID    = 32'd0,
  parameter logic [31:0] MISA_VALUE = MISA_DEFAULT
) (
  input  logic           clock,
  input  logic           reset,
  input  destinationCSR_ readCSR,
  output logic [31:0]    readData,
  output logic           readIllegal,
  input  logic           writeValid,
  input  destinationCSR_ writeCSR,
  input  CSROp_          writeOp,
  input  logic           writeIntent,
  input  logic [31:0]    writeOperand,
  input  logic           retire,
  input  logic           trapValid,
  input  logic [31:0]    trapPC,
  input  logic [31:0]    trapCause,
  input  logic           mretValid,
  output logic [31:0]    trapTarget,
  output logic [31:0]    mretTarget,
  output logic           interruptEnable
);

  logic        mstatusMie;
  logic        mstatusMpie;
  logic [31:0] mieReg;
  logic [31:0] mtvecReg;
  logic [31:0] mscratchReg;
  logic [31:0] mepcReg;
  logic [31:0] mcauseReg;
  logic [31:0] mtvalReg;
  logic [31:0] mcycleCount;
  logic [31:0] minstretCount;

  logic [31:0] csrValues [16];
  logic [31:0] writeCurrent;
  logic [31:0] writeNew;
  logic [31:0] mstatusNew;
  logic        writeCommit;

  // Architectural view of every CSR, indexed by selector. MSTATUS is
  // rebuilt from its two live bits with MPP hard-wired to machine mode.
  always_comb begin
    csrValues = '{default: '0};
    csrValues[CSR_MSTATUS]  = {19'd0, MSTATUS_MPP, 3'd0, mstatusMpie, 3'd0, mstatusMie, 3'd0};
    csrValues[CSR_MISA]     = MISA_VALUE;
    csrValues[CSR_MIE]      = mieReg;
    csrValues[CSR_MTVEC]    = mtvecReg;
    csrValues[CSR_MSCRATCH] = mscratchReg;
    csrValues[CSR_MEPC]     = mepcReg;
    csrValues[CSR_MCAUSE]   = mcauseReg;
    csrValues[CSR_MTVAL]    = mtvalReg;
    csrValues[CSR_MCYCLE]   = mcycleCount;
    csrValues[CSR_MINSTRET] = minstretCount;
    csrValues[CSR_MHARTID]  = HART_ID;
  end

  assign readData    = csrValues[readCSR];
  assign readIllegal = (readCSR == CSR_UNMAPPED);

  assign writeCommit  = writeValid && writeIntent && (writeOp != CSR_NONE);
  assign writeCurrent = csrValues[writeCSR];
  assign writeNew     = csrOpResult(writeOp, writeCurrent, writeOperand);
  assign mstatusNew   = writeNew & MSTATUS_WMASK;

  // Trap entry outranks MRET, which outranks a CSR write, but only for the
  // trap-related registers; MIE/MTVEC/MSCRATCH writes always land.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mstatusMie  <= 1'b0;
      mstatusMpie <= 1'b0;
      mieReg      <= '0;
      mtvecReg    <= '0;
      mscratchReg <= '0;
      mepcReg     <= '0;
      mcauseReg   <= '0;
      mtvalReg    <= '0;
    end else begin
      if (trapValid) begin
        mepcReg     <= trapPC & ~32'd3;
        mcauseReg   <= trapCause;
        mtvalReg    <= '0;
        mstatusMpie <= mstatusMie;
        mstatusMie  <= 1'b0;
      end else begin
        if (mretValid) begin
          mstatusMie  <= mstatusMpie;
          mstatusMpie <= 1'b1;
        end else if (writeCommit && writeCSR == CSR_MSTATUS) begin
          mstatusMie  <= mstatusNew[3];
          mstatusMpie <= mstatusNew[7];
        end
        if (writeCommit && writeCSR == CSR_MEPC)   mepcReg   <= writeNew & ~32'd3;
        if (writeCommit && writeCSR == CSR_MCAUSE) mcauseReg <= writeNew;
        if (writeCommit && writeCSR == CSR_MTVAL)  mtvalReg  <= writeNew;
      end
      if (writeCommit && writeCSR == CSR_MIE)      mieReg      <= writeNew & MIE_WMASK;
      if (writeCommit && writeCSR == CSR_MTVEC)    mtvecReg    <= writeNew & ~32'd3;
      if (writeCommit && writeCSR == CSR_MSCRATCH) mscratchReg <= writeNew;
    end
  end

  csr_counter #(.LOAD_PRIORITY(1'b1)) mcycleCounter (
    .clock      (clock),
    .reset      (reset),
    .incEnable  (1'b1),
    .loadEnable (writeCommit && writeCSR == CSR_MCYCLE),
    .loadValue  (writeNew),
    .count      (mcycleCount)
  );

  csr_counter #(.LOAD_PRIORITY(1'b1)) minstretCounter (
    .clock      (clock),
    .reset      (reset),
    .incEnable  (retire),
    .loadEnable (writeCommit && writeCSR == CSR_MINSTRET),
    .loadValue  (writeNew),
    .count      (minstretCount)
  );

  assign trapTarget      = mtvecReg;
  assign mretTarget      = mepcReg;
  assign interruptEnable = mstatusMie;

endmodule

// File: doc/csr_file.md
CSR_FILE -- requirements
Module: csr_file

Interface
REQ-001 SHALL have parameter HART_ID, default 32'd0, value returned for MHARTID.
REQ-002 SHALL have parameter MISA_VALUE, default 32'h40000100, RV32I value returned for MISA.
REQ-003 SHALL have port clock  input  1  single clock for all state.
REQ-004 SHALL have port reset  input  1  asynchronous active-high reset.
REQ-005 SHALL have port readCSR  input  4 (destinationCSR_)  CSR selected by execute for read.
REQ-006 SHALL have port readData  output  32  current value of readCSR (combinational).
REQ-007 SHALL have port readIllegal  output  1  readCSR is the unmapped encoding 4'b0101.
REQ-008 SHALL have port writeValid  input  1  writeback-stage CSR instruction valid.
REQ-009 SHALL have port writeCSR  input  4 (destinationCSR_)  target CSR.
REQ-010 SHALL have port writeOp  input  2 (CSROp_)  RW/RS/RC/NONE.
REQ-011 SHALL have port writeIntent  input  1  instruction intends a CSR write.
REQ-012 SHALL have port writeOperand  input  32  rs1 value or zero-extended immediate.
REQ-013 SHALL have port retire  input  1  one instruction retired this cycle.
REQ-014 SHALL have ports trapValid/trapPC/trapCause  input  1/32/32  trap entry request and its PC and cause.
REQ-015 SHALL have port mretValid  input  1  MRET committing this cycle.
REQ-016 SHALL have ports trapTarget/mretTarget/interruptEnable  output  32/32/1  MTVEC, MEPC, MSTATUS.MIE.

Function
REQ-017 Commit condition: writeValid and writeIntent and writeOp!=CSR_NONE; update at next clock edge.
REQ-018 New value from current register value V and operand X: RW=X; RS=V|X; RC=V&~X.
REQ-019 Read-only CSRs (MISA, MVENDORID, MARCHID, MIMPID, MHARTID, MIP) and encoding 4'b0101 SHALL ignore writes silently.
REQ-020 MSTATUS writable bits: MIE[3], MPIE[7] only; MPP[12:11] SHALL read 2'b11; others read 0.
REQ-021 MIE writable bits: 3, 7, 11 only; others read 0.
REQ-022 MTVEC and MEPC bits[1:0] SHALL be forced to 0 on every write (direct mode, aligned).
REQ-023 MIP reads 0; MVENDORID/MARCHID/MIMPID read 0; MHARTID reads HART_ID; MISA reads MISA_VALUE; 4'b0101 reads 0.
REQ-024 readData SHALL reflect registered state only; no same-cycle forwarding of the pending write.
REQ-025 MCYCLE SHALL increment by 1 every cycle, wrapping 32'hFFFFFFFF->0; a committed write to MCYCLE wins over the increment that cycle.
REQ-026 MINSTRET SHALL increment when retire=1, wrapping; a committed write to MINSTRET wins that cycle.
REQ-027 On trapValid: MEPC<=trapPC&~3, MCAUSE<=trapCause, MTVAL<=0, MPIE<=MIE, MIE<=0.
REQ-028 On mretValid: MIE<=MPIE, MPIE<=1.
REQ-029 Priority same cycle: trap > mret > CSR write; lower-priority updates to MSTATUS/MEPC/MCAUSE/MTVAL dropped, counter increments unaffected.
REQ-030 trapTarget, mretTarget, interruptEnable SHALL be registered values (one-cycle visibility after update).

Reset
REQ-031 On reset asserted, asynchronously: MSTATUS=32'h00001800, MEPC, MCAUSE, MTVAL, MIE, MTVEC, MSCRATCH, MCYCLE, MINSTRET = 0.
REQ-032 Reset mid-operation SHALL discard any pending write/trap/mret; first increment of MCYCLE on first edge after deassertion.

Structure
REQ-033 Package SHALL hold MSTATUS_WMASK (32'h88), MIE_WMASK (32'h888), MSTATUS_MPP constant, MISA default.
REQ-034 Counters SHALL be one sub-module csr_counter (32-bit, increment enable, load enable, load value, load priority), instantiated twice.

Verification
REQ-035 Reset, read every CSR -> MSTATUS=0x1800, MISA=0x40000100, MHARTID=HART_ID, rest 0; 4'b0101 readIllegal=1.
REQ-036 RW MSCRATCH 0xF0F0, RS 0x000F, RC 0x00F0 -> reads 0xF0F0, 0xF0FF, 0xF00F.
REQ-037 RW MSTATUS 0xFFFFFFFF -> reads 0x1888; RW MTVEC 0x80000103 -> reads 0x80000100; RW MISA 0 -> still 0x40000100.
REQ-038 MIE=1, trap PC 0x80000006 cause 2 with simultaneous RW MEPC 0x1234 -> MEPC 0x80000004, MCAUSE 2, MTVAL 0, MSTATUS 0x1880; then mret -> MSTATUS 0x1888.
REQ-039 RW MCYCLE 0xFFFFFFFE -> next cycle reads 0xFFFFFFFE, then 0xFFFFFFFF, then 0 (wrap).
REQ-040 retire=1 with simultaneous RW MINSTRET 0x10 -> MINSTRET 0x10 (write wins), next retire -> 0x11.
